cpu: RTL and testbench
======================

CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, giving unified instruction/data memory depth in 32-bit words.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have no other ports; observation is by hierarchy only.
REQ-005 SHALL expose these internal names:
- memory instance "memory" holding word array "mem[0:MEM_WORDS-1]", loadable by $readmemh starting at word 0.
- PC_A: current 32-bit PC.
- INS_A: 32-bit instruction register.

Function
REQ-006 SHALL be a multicycle MIPS-I subset core, 32-bit datapath, single unified memory port.
REQ-007 SHALL implement LW, SW, BEQ, BNE, ADDI, XORI, J, JAL; R-type ADD, SUB, SLT, JR.
REQ-008 Memory behaviour:
- word index = address[log2(MEM_WORDS)+1:2].
- upper address bits ignored (wrap modulo memory size).
- low two bits ignored.
- combinational read.
- write on rising clk edge.
REQ-009 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB.
REQ-010 FETCH SHALL load INS_A from mem[PC_A] and set PC_A = PC_A + 4.
REQ-011 DECODE SHALL read rs/rt and compute branch target = PC_A + (sign-extended imm16 << 2).
REQ-012 Cycle counts SHALL be:
- BEQ/BNE/J/JAL/JR: 3 (FETCH, DECODE, EXEC).
- R-type ALU, ADDI, XORI, SW: 4.
- LW: 5.
REQ-013 Immediate extension: ADDI and load/store offsets sign-extended; XORI zero-extended.
REQ-014 Arithmetic overflow SHALL be ignored (wrap, no exception).
REQ-015 SLT SHALL be a signed compare writing 1 or 0.
REQ-016 J/JAL target = {PC_A[31:28], imm26, 2'b00}, computed with the already-incremented PC.
REQ-017 JAL SHALL write register 31 = return address (incremented PC).
REQ-018 JR SHALL set PC_A = rs.
REQ-019 Branch taken SHALL load PC_A with the target in EXEC; not taken leaves PC_A unchanged.
REQ-020 Register $0 SHALL read 0 always; writes to it are discarded.
REQ-021 Unrecognised opcode/funct SHALL execute as a NOP in 3 cycles (no register or memory write).
REQ-022 Register-file read SHALL be combinational; write at the end of WB/EXEC.
REQ-023 Same-cycle read and write of one register returns the old value.

Reset
REQ-024 While reset is low, regardless of clk:
- PC_A = 0.
- INS_A = 0.
- state = FETCH.
- all registers 0 except $sp (r29) = 0x00003FFC.
REQ-025 Memory contents SHALL NOT be altered by reset.
REQ-026 On release of reset, first fetch SHALL occur at the next rising clk edge, at address 0.
REQ-027 Reset asserted mid-instruction SHALL abort it with no pending register or memory write committed.

Configuration
REQ-028 With macro CPU_TRACE_EN defined, each FETCH SHALL $display simulation time, PC_A and the fetched instruction in hex.
REQ-029 Without CPU_TRACE_EN, no trace logic or display SHALL be compiled; function is otherwise identical.

Verification
REQ-030 ADDI $t0,$0,5; ADDI $t1,$0,-3; ADD $t2,$t0,$t1 -> $t2 = 2; SLT $t3,$t1,$t0 -> $t3 = 1.
REQ-031 ADDI $t0,$0,0x1234; SW $t0,0x100($0); LW $t1,0x100($0) -> mem[64] = 0x00001234 and $t1 = 0x00001234.
REQ-032 BEQ $0,$0,+1 at PC 0 -> next fetch at 8; BNE $0,$0,+1 -> next fetch at 4; branch completes in 3 cycles.
REQ-033 JAL to word 0x10 at PC 0 -> $ra = 4, PC_A = 0x40; JR $ra at 0x40 -> PC_A = 4.
REQ-034 Assert reset low during the MEM state of an SW -> target word unchanged, PC_A = 0, $sp = 0x3FFC.
REQ-035 XORI $t0,$0,0xFFFF -> $t0 = 0x0000FFFF; ADDI $0,$0,7 -> $0 reads 0.

Source files
------------

// File: rtl/cpu.sv
// Multicycle MIPS-I subset core on one unified combinational-read memory; CPU_TRACE_EN adds a per-fetch trace.
// Latency 3 (branch/jump/NOP), 4 (ALU/SW) or 5 (LW) cycles per instruction; no backpressure, memory never stalls.

module cpu_mem #(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem [0:WORDS-1];
    logic [AW-1:0] idx;
    logic          unused_addr_bits;

    // Byte offset and bits above the array size are dropped, so addresses wrap.
    assign idx              = addr[AW+1:2];
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
    assign rdata            = mem[idx];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end
endmodule

module cpu #(
    parameter int MEM_WORDS = 4096
) (
    input logic clk,
    input logic reset
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] PC_A, INS_A;
    logic [31:0] regs [0:31];
    logic [31:0] a_q, b_q, tgt_q, alu_q, mdr_q;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] imm26;

    assign op    = INS_A[31:26];
    assign rs    = INS_A[25:21];
    assign rt    = INS_A[20:16];
    assign rd    = INS_A[15:11];
    assign shamt = INS_A[10:6];
    assign funct = INS_A[5:0];
    assign imm16 = INS_A[15:0];
    assign imm26 = INS_A[25:0];

    logic is_rtype, is_add, is_sub, is_slt, is_jr, is_alu_r;
    logic is_lw, is_sw, is_beq, is_bne, is_addi, is_xori, is_j, is_jal;

    // R-type encodings with a non-zero shift amount fall through as NOPs.
    assign is_rtype = (op == 6'h00) && (shamt == 5'd0);
    assign is_add   = is_rtype && (funct == 6'h20);
    assign is_sub   = is_rtype && (funct == 6'h22);
    assign is_slt   = is_rtype && (funct == 6'h2A);
    assign is_jr    = is_rtype && (funct == 6'h08);
    assign is_alu_r = is_add || is_sub || is_slt;
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2B);
    assign is_beq   = (op == 6'h04);
    assign is_bne   = (op == 6'h05);
    assign is_addi  = (op == 6'h08);
    assign is_xori  = (op == 6'h0E);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);

    logic [31:0] sext_imm, zext_imm, alu_b, alu_res, j_tgt;
    logic [31:0] rf_a, rf_b;
    logic        br_taken;

    assign sext_imm = {{16{imm16[15]}}, imm16};
    assign zext_imm = {16'd0, imm16};
    assign j_tgt    = {PC_A[31:28], imm26, 2'b00};
    assign rf_a     = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rf_b     = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign br_taken = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));

    always_comb begin
        alu_b = is_alu_r ? b_q : (is_xori ? zext_imm : sext_imm);
        if (is_sub)       alu_res = a_q - b_q;
        else if (is_slt)  alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
        else if (is_xori) alu_res = a_q ^ alu_b;
        else              alu_res = a_q + alu_b;
    end

    logic [31:0] mem_addr, mem_rdata, pc_nxt, rf_wd;
    logic [4:0]  rf_wa;
    logic        mem_we, ir_ld, ab_ld, alu_ld, mdr_ld, pc_ld, rf_we;

    cpu_mem #(.WORDS(MEM_WORDS)) memory (
        .clk   (clk),
        .addr  (mem_addr),
        .wdata (b_q),
        .we    (mem_we),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: state_nxt = EXEC;
            EXEC: begin
                if (is_lw || is_sw)                      state_nxt = MEM;
                else if (is_alu_r || is_addi || is_xori) state_nxt = WB;
                else                                     state_nxt = FETCH;
            end
            MEM:     state_nxt = is_lw ? WB : FETCH;
            WB:      state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        ir_ld    = 1'b0;
        ab_ld    = 1'b0;
        alu_ld   = 1'b0;
        mdr_ld   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = PC_A;
        pc_ld    = 1'b0;
        pc_nxt   = PC_A + 32'd4;
        rf_we    = 1'b0;
        rf_wa    = rt;
        rf_wd    = alu_q;
        case (state)
            FETCH: begin
                ir_ld = 1'b1;
                pc_ld = 1'b1;
            end
            DECODE: ab_ld = 1'b1;
            EXEC: begin
                alu_ld = 1'b1;
                if (br_taken) begin
                    pc_ld  = 1'b1;
                    pc_nxt = tgt_q;
                end else if (is_j || is_jal) begin
                    pc_ld  = 1'b1;
                    pc_nxt = j_tgt;
                end else if (is_jr) begin
                    pc_ld  = 1'b1;
                    pc_nxt = a_q;
                end
                // PC_A already holds the return address here.
                if (is_jal) begin
                    rf_we = 1'b1;
                    rf_wa = 5'd31;
                    rf_wd = PC_A;
                end
            end
            MEM: begin
                mem_addr = alu_q;
                mdr_ld   = is_lw;
                mem_we   = is_sw;
            end
            WB: begin
                rf_we = 1'b1;
                rf_wa = is_alu_r ? rd : rt;
                rf_wd = is_lw ? mdr_q : alu_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC_A  <= '0;
            INS_A <= '0;
            a_q   <= '0;
            b_q   <= '0;
            tgt_q <= '0;
            alu_q <= '0;
            mdr_q <= '0;
        end else begin
            if (ir_ld) INS_A <= mem_rdata;
            if (pc_ld) PC_A <= pc_nxt;
            if (ab_ld) begin
                a_q   <= rf_a;
                b_q   <= rf_b;
                tgt_q <= PC_A + {sext_imm[29:0], 2'b00};
            end
            if (alu_ld) alu_q <= alu_res;
            if (mdr_ld) mdr_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 29) ? 32'h0000_3FFC : 32'd0;
        end else if (rf_we && (rf_wa != 5'd0)) begin
            regs[rf_wa] <= rf_wd;
        end
    end

`ifdef CPU_TRACE_EN
    always @(posedge clk) begin
        if (reset && (state == FETCH))
            $display("%0t fetch pc=%08h ins=%08h", $time, PC_A, mem_rdata);
    end
`endif
endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: fetch addresses/spacing checked as they happen, final state drained after each program.
module tb_cpu;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    cpu #(.MEM_WORDS(4096)) dut (
        .clk   (clk),
        .reset (reset)
    );

    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_SLT = 6'h2A, F_JR = 6'h08;
    localparam logic [31:0] SPIN = 32'h1000_FFFF;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    int          fq_pc[$];
    int          fq_gap[$];
    string       eq_tag[$];
    int          eq_kind[$];
    int          eq_idx[$];
    logic [31:0] eq_val[$];

    int cyc = 0, last_fetch = 0, fetch_cnt = 0;
    int m_pc, m_gap;

    always @(negedge clk) begin
        cyc++;
        if (reset && (dut.state == 3'd0)) begin
            fetch_cnt++;
            if (fq_pc.size() > 0) begin
                m_pc  = fq_pc.pop_front();
                m_gap = fq_gap.pop_front();
                check($sformatf("fetch_pc#%0d", fetch_cnt), dut.PC_A, m_pc);
                if (m_gap > 0)
                    check($sformatf("fetch_gap@%08h", m_pc), cyc - last_fetch, m_gap);
            end
            last_fetch = cyc;
        end
    end

    task automatic put(input int addr, input logic [31:0] w);
        dut.memory.mem[addr >> 2] = w;
    endtask

    task automatic exp_fetch(input int pc, input int gap);
        fq_pc.push_back(pc);
        fq_gap.push_back(gap);
    endtask

    // kind: 0 register, 1 memory word, 2 PC_A, 3 INS_A, 4 state
    task automatic exp_state(input string tag, input int kind, input int idx, input logic [31:0] v);
        eq_tag.push_back(tag);
        eq_kind.push_back(kind);
        eq_idx.push_back(idx);
        eq_val.push_back(v);
    endtask

    task automatic drain();
        logic [31:0] got;
        int          k, i;
        while (eq_tag.size() > 0) begin
            k = eq_kind.pop_front();
            i = eq_idx.pop_front();
            case (k)
                0:       got = dut.regs[i];
                1:       got = dut.memory.mem[i];
                2:       got = dut.PC_A;
                3:       got = dut.INS_A;
                default: got = {29'd0, dut.state};
            endcase
            check(eq_tag.pop_front(), got, eq_val.pop_front());
        end
    endtask

    task automatic release_reset();
        fetch_cnt = 0;
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic wait_fetches(input int n);
        int waited = 0;
        while (fetch_cnt < n && waited < 400) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("fetch_count", fetch_cnt, n);
        check("fetch_q_drained", fq_pc.size(), 0);
    endtask

    task automatic run(input int n);
        release_reset();
        wait_fetches(n);
        drain();
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int waited;
        #3 reset = 1'b0;

        // Arithmetic: ADDI, ADD, SUB, signed SLT both ways.
        put(0,  enc_i(OP_ADDI, 0, 8, 16'd5));
        put(4,  enc_i(OP_ADDI, 0, 9, 16'hFFFD));
        put(8,  enc_r(8, 9, 10, F_ADD));
        put(12, enc_r(9, 8, 11, F_SLT));
        put(16, enc_r(8, 9, 12, F_SUB));
        put(20, enc_r(8, 9, 13, F_SLT));
        put(24, SPIN);
        exp_fetch(0, -1);
        for (int a = 4; a <= 24; a += 4) exp_fetch(a, 4);
        exp_state("t0", 0, 8, 32'd5);
        exp_state("t1", 0, 9, 32'hFFFF_FFFD);
        exp_state("add", 0, 10, 32'd2);
        exp_state("slt_true", 0, 11, 32'd1);
        exp_state("sub", 0, 12, 32'd8);
        exp_state("slt_false", 0, 13, 32'd0);
        run(7);

        #1;
        exp_state("rst_pc", 2, 0, 32'd0);
        exp_state("rst_ins", 3, 0, 32'd0);
        exp_state("rst_state", 4, 0, 32'd0);
        exp_state("rst_sp", 0, 29, 32'h0000_3FFC);
        exp_state("rst_t2", 0, 10, 32'd0);
        drain();

        // Loads/stores, address wrap and ignored byte offset.
        put(0,  enc_i(OP_ADDI, 0, 8, 16'h1234));
        put(4,  enc_i(OP_SW, 0, 8, 16'h0100));
        put(8,  enc_i(OP_LW, 0, 9, 16'h0100));
        put(12, enc_i(OP_ADDI, 0, 10, 16'h2345));
        put(16, enc_i(OP_SW, 0, 10, 16'h4104));
        put(20, enc_i(OP_LW, 0, 11, 16'h0103));
        put(24, SPIN);
        put(32'h100, 32'd0);
        put(32'h104, 32'd0);
        exp_fetch(0, -1);
        exp_fetch(4, 4);
        exp_fetch(8, 4);
        exp_fetch(12, 5);
        exp_fetch(16, 4);
        exp_fetch(20, 4);
        exp_fetch(24, 5);
        exp_state("sw_mem64", 1, 64, 32'h0000_1234);
        exp_state("lw_t1", 0, 9, 32'h0000_1234);
        exp_state("sw_wrap_mem65", 1, 65, 32'h0000_2345);
        exp_state("lw_lowbits", 0, 11, 32'h0000_1234);
        run(7);

        // Branches taken and not taken.
        put(0,  enc_i(OP_BEQ, 0, 0, 16'd1));
        put(4,  enc_i(OP_ADDI, 0, 8, 16'd1));
        put(8,  enc_i(OP_BNE, 0, 0, 16'd1));
        put(12, enc_i(OP_ADDI, 0, 9, 16'd7));
        put(16, enc_i(OP_BNE, 9, 0, 16'd1));
        put(20, enc_i(OP_ADDI, 0, 10, 16'd1));
        put(24, enc_i(OP_BEQ, 9, 0, 16'd1));
        put(28, SPIN);
        exp_fetch(0, -1);
        exp_fetch(8, 3);
        exp_fetch(12, 3);
        exp_fetch(16, 4);
        exp_fetch(24, 3);
        exp_fetch(28, 3);
        exp_state("beq_skipped", 0, 8, 32'd0);
        exp_state("bne_skipped", 0, 10, 32'd0);
        exp_state("t1_after_br", 0, 9, 32'd7);
        run(6);

        // Jumps, link, JR, and NOPs for unknown opcode/funct.
        put(0,      enc_j(OP_JAL, 26'h10));
        put(32'h40, enc_r(31, 0, 0, F_JR));
        put(4,      enc_j(OP_J, 26'h20));
        put(32'h80, enc_i(OP_ADDI, 0, 8, 16'd9));
        put(32'h84, 32'hFD08_FFFF);
        put(32'h88, enc_r(8, 8, 8, 6'h3F));
        put(32'h8C, SPIN);
        exp_fetch(0, -1);
        exp_fetch(32'h40, 3);
        exp_fetch(4, 3);
        exp_fetch(32'h80, 3);
        exp_fetch(32'h84, 4);
        exp_fetch(32'h88, 3);
        exp_fetch(32'h8C, 3);
        exp_state("jal_ra", 0, 31, 32'd4);
        exp_state("nop_t0", 0, 8, 32'd9);
        run(7);

        // XORI zero-extension and $0 immutability.
        put(0,  enc_i(OP_XORI, 0, 8, 16'hFFFF));
        put(4,  enc_i(OP_ADDI, 0, 0, 16'd7));
        put(8,  enc_i(OP_ADDI, 0, 9, 16'hFFFF));
        put(12, enc_i(OP_XORI, 9, 10, 16'h00F0));
        put(16, enc_r(0, 8, 11, F_ADD));
        put(20, SPIN);
        exp_fetch(0, -1);
        for (int a = 4; a <= 20; a += 4) exp_fetch(a, 4);
        exp_state("xori_t0", 0, 8, 32'h0000_FFFF);
        exp_state("r0_zero", 0, 0, 32'd0);
        exp_state("addi_neg1", 0, 9, 32'hFFFF_FFFF);
        exp_state("xori_mix", 0, 10, 32'hFFFF_FF0F);
        exp_state("add_r0", 0, 11, 32'h0000_FFFF);
        run(6);

        // Reset during the MEM cycle of a store must drop the write.
        put(0, enc_i(OP_ADDI, 0, 8, 16'h0055));
        put(4, enc_i(OP_SW, 0, 8, 16'h0100));
        put(8, SPIN);
        put(32'h100, 32'hDEAD_BEEF);
        exp_fetch(0, -1);
        exp_fetch(4, 4);
        release_reset();
        wait_fetches(2);
        waited = 0;
        while (dut.state != 3'd3 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("sw_reached_mem", {29'd0, dut.state}, 32'd3);
        reset = 1'b0;
        exp_state("abort_mem64", 1, 64, 32'hDEAD_BEEF);
        exp_state("abort_pc", 2, 0, 32'd0);
        exp_state("abort_sp", 0, 29, 32'h0000_3FFC);
        exp_state("abort_t0", 0, 8, 32'd0);
        @(posedge clk);
        #1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
